// File: rtl/mycpu_pkg.sv
// Shared CPU types: PC operation codes, fetch FSM states and the fetch bubble constant.
package mycpu_pkg;

  typedef enum logic [1:0] {
    PC_NOP = 2'b00,
    PC_INC = 2'b01,
    PC_BRA = 2'b10,
    PC_JMP = 2'b11
  } pc_t;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'b00,
    IF_FETCH   = 2'b01,
    IF_HOLD    = 2'b10,
    IF_DISCARD = 2'b11
  } ifetch_state_t;

  localparam logic [15:0] IFETCH_NOP_INSTR = 16'h0000;

  function automatic pc_t redir_op(input logic jmp);
    return jmp ? PC_JMP : PC_BRA;
  endfunction

endpackage

// File: rtl/ifetch_perf.sv
// Free-running, wrapping counters for completed and discarded instruction fetches.
module ifetch_perf #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_inc,
  input  logic          flush_inc,
  output logic [CW-1:0] fetch_cnt,
  output logic [CW-1:0] flush_cnt
);

  logic [CW-1:0] fetch_cnt_r;
  logic [CW-1:0] flush_cnt_r;

  // Count events; both counters wrap naturally at 2^CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r <= {CW{1'b0}};
      flush_cnt_r <= {CW{1'b0}};
    end else begin
      if (fetch_inc) begin
        fetch_cnt_r <= fetch_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      if (flush_inc) begin
        flush_cnt_r <= flush_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fetch_cnt = fetch_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the PC, talks req/ack to imem and valid/ready to decode.
// Performance counters are built only when IFETCH_PERF_EN is defined.
module ifetch_ctrl
  import mycpu_pkg::*;
#(
  parameter int AW = 16,
  parameter int IW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_in,
  output pc_t           ps_out,
  output logic [AW-1:0] ia_out,
  output logic [AW-1:0] ra_out,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [IW-1:0] ir_out,
  output logic [AW-1:0] ir_pc,
  input  logic          redir_valid,
  input  logic          redir_jmp,
  input  logic [AW-1:0] redir_imm,
  input  logic [AW-1:0] redir_addr,
  output logic [CW-1:0] fetch_cnt,
  output logic [CW-1:0] flush_cnt
);

  ifetch_state_t state_r;
  logic [AW-1:0] hold_addr_r;
  logic [IW-1:0] ir_out_r;
  logic [AW-1:0] ir_pc_r;
  logic          ir_valid_r;
  logic          redir_s;
  logic          fetch_done_s;
  logic          flush_s;

  // The first cycle after reset is reserved, so redirects there are dropped.
  assign redir_s = redir_valid && (state_r != IF_IDLE);

  // PC command, memory request and counter events for the current cycle.
  always_comb begin
    ps_out       = PC_NOP;
    ia_out       = {AW{1'b0}};
    ra_out       = {AW{1'b0}};
    imem_req     = 1'b0;
    imem_addr    = pc_in;
    fetch_done_s = 1'b0;
    flush_s      = 1'b0;
    if (redir_s) begin
      ps_out = redir_op(redir_jmp);
      ia_out = redir_imm;
      ra_out = redir_addr;
    end else if ((state_r == IF_HOLD) && ir_valid_r && ir_ready) begin
      ps_out = PC_INC;
    end else begin
      ps_out = PC_NOP;
    end
    case (state_r)
      IF_FETCH: begin
        imem_req     = 1'b1;
        imem_addr    = pc_in;
        fetch_done_s = imem_ack && !redir_s;
        flush_s      = imem_ack && redir_s;
      end
      IF_DISCARD: begin
        // pc_in has already moved; keep presenting the stale address until ack.
        imem_req  = 1'b1;
        imem_addr = hold_addr_r;
        flush_s   = imem_ack;
      end
      IF_HOLD: begin
        flush_s = redir_s;
      end
      IF_IDLE: begin
        imem_req = 1'b0;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Fetch FSM with the instruction register and the held discard address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IF_IDLE;
      hold_addr_r <= {AW{1'b0}};
      ir_out_r    <= IW'(IFETCH_NOP_INSTR);
      ir_pc_r     <= {AW{1'b0}};
      ir_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        IF_IDLE: begin
          state_r <= IF_FETCH;
        end
        IF_FETCH: begin
          if (redir_s) begin
            if (imem_ack) begin
              state_r <= IF_FETCH;
            end else begin
              hold_addr_r <= pc_in;
              state_r     <= IF_DISCARD;
            end
          end else if (imem_ack) begin
            ir_out_r   <= imem_rdata;
            ir_pc_r    <= pc_in;
            ir_valid_r <= 1'b1;
            state_r    <= IF_HOLD;
          end else begin
            state_r <= IF_FETCH;
          end
        end
        IF_HOLD: begin
          if (redir_s || ir_ready) begin
            ir_valid_r <= 1'b0;
            state_r    <= IF_FETCH;
          end else begin
            state_r <= IF_HOLD;
          end
        end
        IF_DISCARD: begin
          if (imem_ack) begin
            state_r <= IF_FETCH;
          end else begin
            state_r <= IF_DISCARD;
          end
        end
        default: begin
          ir_valid_r <= 1'b0;
          state_r    <= IF_IDLE;
        end
      endcase
    end
  end

  assign ir_valid = ir_valid_r;
  assign ir_out   = ir_out_r;
  assign ir_pc    = ir_pc_r;

`ifdef IFETCH_PERF_EN
  ifetch_perf #(.CW(CW)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_inc (fetch_done_s),
    .flush_inc (flush_s),
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  logic perf_unused_s;
  assign perf_unused_s = fetch_done_s ^ flush_s;
  assign fetch_cnt     = {CW{1'b0}};
  assign flush_cnt     = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: PC and memory models, instruction scoreboard, redirect vector table.
module tb_ifetch_ctrl;
  import mycpu_pkg::*;

  localparam int AW = 16;
  localparam int IW = 16;
  localparam int CW = 16;
`ifdef IFETCH_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_r;
  pc_t           ps_out;
  logic [AW-1:0] ia_out, ra_out, imem_addr, ir_pc, redir_imm, redir_addr;
  logic          imem_req, imem_ack, ir_valid, ir_ready, redir_valid, redir_jmp;
  logic [IW-1:0] imem_rdata, ir_out;
  logic [CW-1:0] fetch_cnt, flush_cnt;

  typedef struct packed { logic [AW-1:0] pc; logic [IW-1:0] instr; } exp_t;
  typedef struct {
    logic jmp; logic [AW-1:0] addr; logic [AW-1:0] imm; logic ready;
    pc_t exp_ps; logic [AW-1:0] exp_ia; logic [AW-1:0] exp_ra;
  } vec_t;

  exp_t          sb_q[$];
  exp_t          sb_e;
  vec_t          vecs[4];
  int            total = 0, bad = 0;
  int            lat = 0, wait_cnt;
  int            exp_fetch = 0, exp_flush = 0;
  logic [AW-1:0] exp_pc;
  logic          prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always #5 clk = ~clk;

  ifetch_ctrl #(.AW(AW), .IW(IW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_r), .ps_out(ps_out), .ia_out(ia_out), .ra_out(ra_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_out(ir_out), .ir_pc(ir_pc),
    .redir_valid(redir_valid), .redir_jmp(redir_jmp), .redir_imm(redir_imm),
    .redir_addr(redir_addr), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [IW-1:0] mem_f(input logic [AW-1:0] a);
    return a ^ 16'h1234;
  endfunction

  function automatic logic [31:0] cnt_exp(input int n);
    return 32'(PERF * n);
  endfunction

  // PC register driven by the controller's commands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_r <= '0;
    else begin
      case (ps_out)
        PC_INC:  pc_r <= pc_r + 16'd1;
        PC_BRA:  pc_r <= pc_r + ia_out;
        PC_JMP:  pc_r <= ra_out;
        default: pc_r <= pc_r;
      endcase
    end
  end

  // Memory with a configurable number of wait cycles before ack.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem_f(imem_addr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every instruction decode accepts must match the next expected entry.
  always @(negedge clk) begin
    #2;
    if (rst_n && ir_valid && ir_ready && !redir_valid) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected actual_pc=%0h required=none", ir_pc);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_pc", 32'(ir_pc), 32'(sb_e.pc));
        chk("sb_instr", 32'(ir_out), 32'(sb_e.instr));
      end
    end
  end

  // An outstanding request must keep req and address stable until ack.
  always @(negedge clk) begin
    #3;
    if (rst_n && prev_pend) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", 32'(imem_addr), 32'(prev_addr));
    end
    prev_pend <= rst_n && imem_req && !imem_ack;
    prev_addr <= imem_addr;
  end

  task automatic wait_valid();
    int n = 0;
    while (!ir_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(ir_valid), 32'd1);
    if (ir_valid) exp_fetch++;
  endtask

  task automatic accept_one();
    sb_q.push_back(exp_t'({exp_pc, mem_f(exp_pc)}));
    exp_pc = exp_pc + 16'd1;
    ir_ready = 1'b1;
    #1;
    chk("ps_inc", 32'(ps_out), 32'(PC_INC));
    chk("ia_idle", 32'(ia_out), 32'd0);
    @(negedge clk);
    ir_ready = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] target, held;
    int n;
    logic acked;
    vecs[0] = '{1'b1, 16'h0040, 16'h0000, 1'b1, PC_JMP, 16'h0000, 16'h0040};
    vecs[1] = '{1'b0, 16'h0000, 16'h0005, 1'b0, PC_BRA, 16'h0005, 16'h0000};
    vecs[2] = '{1'b0, 16'h1234, 16'hFFF0, 1'b1, PC_BRA, 16'hFFF0, 16'h1234};
    vecs[3] = '{1'b1, 16'h0100, 16'h0007, 1'b0, PC_JMP, 16'h0007, 16'h0100};
    rst_n = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0; redir_jmp = 1'b0;
    redir_imm = '0; redir_addr = '0; exp_pc = '0;

    #12;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir_out", 32'(ir_out), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_ps", 32'(ps_out), 32'(PC_NOP));
    chk("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_ps", 32'(ps_out), 32'(PC_NOP));
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0000);
    @(negedge clk);
    wait_valid();
    chk("first_ir_out", 32'(ir_out), 32'h1234);
    chk("first_ir_pc", 32'(ir_pc), 32'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ir_out", 32'(ir_out), 32'h1234);
      chk("stall_ps", 32'(ps_out), 32'(PC_NOP));
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    accept_one();
    wait_valid();
    accept_one();

    for (int i = 0; i < 4; i++) begin
      wait_valid();
      target = vecs[i].jmp ? vecs[i].addr : pc_r + vecs[i].imm;
      redir_valid = 1'b1; redir_jmp = vecs[i].jmp; redir_imm = vecs[i].imm;
      redir_addr = vecs[i].addr; ir_ready = vecs[i].ready;
      #1;
      chk("vec_ps", 32'(ps_out), 32'(vecs[i].exp_ps));
      chk("vec_ia", 32'(ia_out), 32'(vecs[i].exp_ia));
      chk("vec_ra", 32'(ra_out), 32'(vecs[i].exp_ra));
      @(negedge clk);
      redir_valid = 1'b0; ir_ready = 1'b0;
      exp_flush++; exp_pc = target;
      chk("vec_valid_drop", 32'(ir_valid), 32'd0);
      chk("vec_refetch_req", 32'(imem_req), 32'd1);
      chk("vec_refetch_addr", 32'(imem_addr), 32'(target));
      chk("vec_flush_cnt", 32'(flush_cnt), cnt_exp(exp_flush));
      wait_valid();
      accept_one();
    end
    chk("fetch_cnt", 32'(fetch_cnt), cnt_exp(exp_fetch));

    lat = 3;
    wait_valid();
    accept_one();
    held = pc_r;
    target = pc_r + 16'hFFFE;
    redir_valid = 1'b1; redir_jmp = 1'b0; redir_imm = 16'hFFFE; redir_addr = 16'h0000;
    #1;
    chk("bra_ps", 32'(ps_out), 32'(PC_BRA));
    chk("bra_ia", 32'(ia_out), 32'hFFFE);
    chk("bra_addr", 32'(imem_addr), 32'(held));
    @(negedge clk);
    redir_valid = 1'b0; exp_flush++; exp_pc = target;
    n = 0; acked = 1'b0;
    while (!acked && n < 10) begin
      chk("dis_req", 32'(imem_req), 32'd1);
      chk("dis_addr", 32'(imem_addr), 32'(held));
      chk("dis_valid", 32'(ir_valid), 32'd0);
      acked = imem_ack;
      @(negedge clk);
      n++;
    end
    chk("dis_acked", 32'(acked), 32'd1);
    chk("dis_refetch_addr", 32'(imem_addr), 32'(target));
    chk("dis_flush_cnt", 32'(flush_cnt), cnt_exp(exp_flush));
    wait_valid();
    accept_one();

    chk("mid_req", 32'(imem_req), 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_valid", 32'(ir_valid), 32'd0);
    chk("async_ps", 32'(ps_out), 32'(PC_NOP));
    chk("async_fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("async_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; lat = 0; exp_pc = '0; exp_fetch = 0; exp_flush = 0;
    wait_valid();
    accept_one();
    chk("post_rst_fetch_cnt", 32'(fetch_cnt), cnt_exp(exp_fetch));
    chk("post_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
